alu64_issue_stage: RTL and testbench

//  Upstream feeder for ALU64. Buffers {a,b,op} requests in a small FIFO behind a valid/ready

---
 rtl/alu64_pkg.sv | 24 ++
 rtl/alu64_issue_stage_if.sv | 37 +++
 rtl/alu64_req_fifo.sv | 71 +++++++
 rtl/alu64_issue_stage.sv | 90 +++++++++
 tb/tb_alu64_issue_stage.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu64_pkg.sv
// Shared ALU64 definitions: op codes and the request word queued ahead of the ALU.
// Used by the issue stage, the ALU itself and the bench.
package alu64_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 4'd0;
    localparam alu_op_t OP_SUB  = 4'd1;
    localparam alu_op_t OP_AND  = 4'd2;
    localparam alu_op_t OP_OR   = 4'd3;
    localparam alu_op_t OP_XOR  = 4'd4;
    localparam alu_op_t OP_SLL  = 4'd5;
    localparam alu_op_t OP_SRL  = 4'd6;
    localparam alu_op_t OP_SRA  = 4'd7;
    localparam alu_op_t OP_SLT  = 4'd8;
    localparam alu_op_t OP_SLTU = 4'd9;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        alu_op_t     op;
    } req_t;

endpackage

// File: rtl/alu64_issue_stage_if.sv
// Request, ALU-drive and tagged-result signals of the ALU64 issue stage.
// slave = the issue stage, master = the producer/ALU/consumer side.
interface alu64_issue_stage_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    import alu64_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             issue_en;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    alu_op_t          in_op;
    logic [CW-1:0]    count;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    alu_op_t          alu_op;
    logic [63:0]      alu_result;
    logic             res_valid;
    logic [63:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    modport slave (
        input  flush, issue_en, in_valid, in_a, in_b, in_op, alu_result,
        output in_ready, count, alu_a, alu_b, alu_op, res_valid, res_data, res_tag
    );

    modport master (
        output flush, issue_en, in_valid, in_a, in_b, in_op, alu_result,
        input  in_ready, count, alu_a, alu_b, alu_op, res_valid, res_data, res_tag
    );

endinterface

// File: rtl/alu64_req_fifo.sv
// DEPTH-entry request FIFO with sync flush; head visible combinationally, one-edge write latency.
// Caller never pushes when full nor pops when empty; count is the only occupancy source.
module alu64_req_fifo
    import alu64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  req_t                       push_dat,
    input  logic                       pop,
    output req_t                       pop_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_t          mem_q [DEPTH];
    req_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/alu64_issue_stage.sv
// Queues ALU64 requests, issues one per cycle into registered operands and returns tagged results.
// Accept-to-result is 2+ALU_LATENCY cycles; in_ready drops only when the FIFO is full, results have no backpressure.
module alu64_issue_stage
    import alu64_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1,
    parameter int TAG_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu64_issue_stage_if.slave  io
);

    localparam int CW = $clog2(DEPTH) + 1;

    req_t          in_req;
    req_t          head_dat;
    logic [CW-1:0] fifo_count;
    logic          push_vld;
    logic          pop_vld;

    req_t             issue_q, issue_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    // Stage 0 shadows the issue register; stages 1..ALU_LATENCY shadow the ALU pipeline.
    logic [ALU_LATENCY:0]             pipe_vld_q, pipe_vld_d;
    logic [ALU_LATENCY:0][TAG_W-1:0]  pipe_tag_q, pipe_tag_d;

    assign in_req      = '{a: io.in_a, b: io.in_b, op: io.in_op};
    assign io.in_ready = (fifo_count != CW'(DEPTH));
    assign push_vld    = io.in_valid && io.in_ready && !io.flush;
    assign pop_vld     = io.issue_en && (fifo_count != '0) && !io.flush;

    alu64_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (io.flush),
        .push     (push_vld),
        .push_dat (in_req),
        .pop      (pop_vld),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    always_comb begin
        issue_d    = issue_q;
        tag_d      = tag_q;
        pipe_vld_d = pipe_vld_q;
        pipe_tag_d = pipe_tag_q;
        for (int i = 1; i <= ALU_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        pipe_vld_d[0] = pop_vld;
        pipe_tag_d[0] = tag_q;
        if (pop_vld) begin
            issue_d = head_dat;
            tag_d   = tag_q + TAG_W'(1);
        end
        if (io.flush) begin
            pipe_vld_d = '0;
            tag_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q    <= '0;
            tag_q      <= '0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            issue_q    <= issue_d;
            tag_q      <= tag_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
        end
    end

    assign io.count     = fifo_count;
    assign io.alu_a     = issue_q.a;
    assign io.alu_b     = issue_q.b;
    assign io.alu_op    = issue_q.op;
    assign io.res_valid = pipe_vld_q[ALU_LATENCY];
    assign io.res_tag   = pipe_tag_q[ALU_LATENCY];
    assign io.res_data  = pipe_vld_q[ALU_LATENCY] ? io.alu_result : 64'd0;

endmodule

// File: tb/tb_alu64_issue_stage.sv
// Bench for alu64_issue_stage: a one-register ALU64 stand-in, a queue-based reference model,
// a per-cycle compare process and directed scenarios followed by random traffic.
module tb_alu64_issue_stage;
    import alu64_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int TAG_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu64_issue_stage_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) io ();

    alu64_issue_stage #(
        .DEPTH       (DEPTH),
        .ALU_LATENCY (LAT),
        .TAG_W       (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input alu_op_t op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[5:0];
            OP_SRL:  return a >> b[5:0];
            OP_SRA:  return $signed(a) >>> b[5:0];
            OP_SLT:  return {63'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {63'd0, a < b};
            default: return 64'd0;
        endcase
    endfunction

    // ALU64 stand-in with one register of latency
    logic [63:0] alu_res_q;
    always @(posedge clk) alu_res_q <= alu_fn(io.alu_a, io.alu_b, io.alu_op);
    assign io.alu_result = alu_res_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: queued requests, expected completions with the edge they become visible
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
        int               due;
    } exp_t;

    req_t m_fifo[$];
    exp_t m_fly[$];
    req_t m_issue;
    int   m_tag;
    int   edge_cnt;
    bit   chk_on;

    task automatic model_reset();
        m_fifo.delete();
        m_fly.delete();
        m_issue = '0;
        m_tag   = 0;
    endtask

    task automatic model_step();
        req_t r;
        bit   do_pop;
        bit   do_push;
        edge_cnt++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        while (m_fly.size() > 0 && m_fly[0].due < edge_cnt) void'(m_fly.pop_front());
        if (io.flush) begin
            m_fifo.delete();
            m_fly.delete();
            m_tag = 0;
        end else begin
            do_pop  = io.issue_en && (m_fifo.size() > 0);
            do_push = io.in_valid && (m_fifo.size() < DEPTH);
            if (do_pop) begin
                r       = m_fifo.pop_front();
                m_issue = r;
                m_fly.push_back('{tag: TAG_W'(m_tag), res: alu_fn(r.a, r.b, r.op), due: edge_cnt + LAT});
                m_tag   = (m_tag + 1) % (1 << TAG_W);
            end
            if (do_push) m_fifo.push_back('{a: io.in_a, b: io.in_b, op: io.in_op});
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_v;
            exp_v = (m_fly.size() > 0) && (m_fly[0].due == edge_cnt);
            chk("count",     64'(io.count),    64'(m_fifo.size()));
            chk("in_ready",  64'(io.in_ready), 64'(m_fifo.size() != DEPTH));
            chk("alu_a",     io.alu_a,         m_issue.a);
            chk("alu_b",     io.alu_b,         m_issue.b);
            chk("alu_op",    64'(io.alu_op),   64'(m_issue.op));
            chk("res_valid", 64'(io.res_valid), 64'(exp_v));
            if (exp_v) begin
                chk("res_tag",  64'(io.res_tag), 64'(m_fly[0].tag));
                chk("res_data", io.res_data,     m_fly[0].res);
            end else begin
                chk("res_data_idle", io.res_data, 64'd0);
            end
        end
    end

    int               tick_cnt;
    logic [63:0]      got_d[$];
    logic [TAG_W-1:0] got_t[$];
    int               got_c[$];

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        tick_cnt++;
        if (io.res_valid === 1'b1) begin
            got_d.push_back(io.res_data);
            got_t.push_back(io.res_tag);
            got_c.push_back(tick_cnt);
        end
    endtask

    task automatic clr_got();
        got_d.delete();
        got_t.delete();
        got_c.delete();
    endtask

    task automatic drive_req(input logic v, input logic [63:0] a, input logic [63:0] b, input alu_op_t op);
        io.in_valid = v;
        io.in_a     = a;
        io.in_b     = b;
        io.in_op    = op;
    endtask

    task automatic flush_pulse();
        io.flush = 1'b1;
        tick();
        io.flush = 1'b0;
    endtask

    initial begin
        int t0;
        io.flush    = 1'b0;
        io.issue_en = 1'b0;
        drive_req(1'b0, 64'd0, 64'd0, OP_ADD);
        model_reset();
        edge_cnt = 0;
        tick_cnt = 0;
        chk_on   = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_count",    64'(io.count),     64'd0);
        chk("rst_in_ready", 64'(io.in_ready),  64'd1);
        chk("rst_res_vld",  64'(io.res_valid), 64'd0);
        chk("rst_alu_a",    io.alu_a,          64'd0);
        rst_n = 1'b1;
        tick();

        // 1+2: single requests, latency and carry-out dropped
        clr_got();
        io.issue_en = 1'b1;
        t0 = tick_cnt;
        drive_req(1'b1, 64'd1, 64'd2, OP_ADD);
        tick();
        io.in_valid = 1'b0;
        repeat (5) tick();
        drive_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
        tick();
        io.in_valid = 1'b0;
        repeat (5) tick();
        chk("t12_nres", 64'(got_d.size()), 64'd2);
        if (got_d.size() == 2) begin
            chk("t1_latency", 64'(got_c[0] - t0), 64'd3);
            chk("t1_data",    got_d[0],           64'd3);
            chk("t1_tag",     64'(got_t[0]),      64'd0);
            chk("t2_data",    got_d[1],           64'd0);
            chk("t2_tag",     64'(got_t[1]),      64'd1);
        end

        // 3: fill to full with issue disabled, then drain
        flush_pulse();
        clr_got();
        io.issue_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_req(1'b1, 64'(100 + k), 64'(k), OP_ADD);
            tick();
        end
        chk("t3_count_full", 64'(io.count),    64'd4);
        chk("t3_ready_full", 64'(io.in_ready), 64'd0);
        io.in_valid = 1'b0;
        io.issue_en = 1'b1;
        tick();
        chk("t3_ready_pop", 64'(io.in_ready), 64'd1);
        chk("t3_count_pop", 64'(io.count),    64'd3);
        repeat (8) tick();
        chk("t3_nres", 64'(got_d.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                chk("t3_tag",  64'(got_t[i]), 64'(i));
                chk("t3_data", got_d[i],      64'(100 + 2 * i));
                if (i > 0) chk("t3_consec", 64'(got_c[i] - got_c[i-1]), 64'd1);
            end
        end

        // 4: back-to-back stream, tag wraps
        flush_pulse();
        clr_got();
        io.issue_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 5) drive_req(1'b1, 64'(k), 64'(k), OP_ADD);
            else       io.in_valid = 1'b0;
            tick();
        end
        chk("t4_nres", 64'(got_d.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_d.size()) begin
                chk("t4_data", got_d[i],      64'(2 * i));
                chk("t4_tag",  64'(got_t[i]), 64'(i % 4));
            end
        end

        // 5: flush with three queued and one in flight
        flush_pulse();
        io.issue_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 64'(50 + k), 64'd1, OP_SUB);
            tick();
        end
        io.in_valid = 1'b0;
        io.issue_en = 1'b1;
        tick();
        io.issue_en = 1'b0;
        clr_got();
        drive_req(1'b1, 64'd9, 64'd9, OP_ADD);
        flush_pulse();
        io.in_valid = 1'b0;
        repeat (6) tick();
        chk("t5_nres",  64'(got_d.size()), 64'd0);
        chk("t5_count", 64'(io.count),     64'd0);
        io.issue_en = 1'b1;
        drive_req(1'b1, 64'd7, 64'd8, OP_ADD);
        tick();
        io.in_valid = 1'b0;
        repeat (5) tick();
        chk("t5_after_n", 64'(got_d.size()), 64'd1);
        if (got_d.size() == 1) begin
            chk("t5_after_tag",  64'(got_t[0]), 64'd0);
            chk("t5_after_data", got_d[0],      64'd15);
        end

        // 6: asynchronous reset in the middle of a stream
        io.issue_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 64'(20 + k), 64'd3, OP_XOR);
            tick();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_count",    64'(io.count),     64'd0);
        chk("t6_in_ready", 64'(io.in_ready),  64'd1);
        chk("t6_res_vld",  64'(io.res_valid), 64'd0);
        chk("t6_res_data", io.res_data,       64'd0);
        chk("t6_res_tag",  64'(io.res_tag),   64'd0);
        chk("t6_alu_a",    io.alu_a,          64'd0);
        chk("t6_alu_b",    io.alu_b,          64'd0);
        chk("t6_alu_op",   64'(io.alu_op),    64'd0);
        io.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clr_got();
        drive_req(1'b1, 64'd40, 64'd2, OP_SLL);
        tick();
        io.in_valid = 1'b0;
        repeat (5) tick();
        chk("t6_after_n", 64'(got_d.size()), 64'd1);
        if (got_d.size() == 1) begin
            chk("t6_after_tag",  64'(got_t[0]), 64'd0);
            chk("t6_after_data", got_d[0],      64'd160);
        end

        // Random traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            io.flush    = ($urandom_range(0, 99) < 2);
            io.issue_en = ($urandom_range(0, 99) < 70);
            drive_req($urandom_range(0, 99) < 60,
                      {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      alu_op_t'($urandom_range(0, 9)));
            tick();
        end
        io.flush    = 1'b0;
        io.in_valid = 1'b0;
        io.issue_en = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
